// File: rtl/reg_a_if.sv
`default_nettype none
// ============================================================================
//  Module      : reg_a_if
//  Description : Load/data bus for the reg_a storage register.
//                The master drives the load enable and the data.
//                The register returns its stored contents.
//  Revision    : 1.0 - initial release
// ============================================================================
interface reg_a_if #(
    parameter int WIDTH = 16
);
    logic             loadA;
    logic [WIDTH-1:0] dataAin;
    logic [WIDTH-1:0] dataAout;

    modport master (
        output loadA,
        output dataAin,
        input  dataAout
    );

    modport slave (
        input  loadA,
        input  dataAin,
        output dataAout
    );
endinterface
`default_nettype wire

// File: rtl/reg_a.sv
`default_nettype none
// ============================================================================
//  Module      : reg_a
//  Description : WIDTH-bit storage register with a load enable and a
//                synchronous active-high reset. Reset takes priority over
//                load. The output is driven directly from the flops.
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_a #(
    parameter int WIDTH = 16
) (
    input  wire logic clk,
    input  wire logic reset,
    reg_a_if.slave    bus
);

    logic [WIDTH-1:0] dataA_q;
    logic [WIDTH-1:0] dataA_d;

    // Next-state value: capture the whole input word on load, otherwise hold
    always_comb begin
        dataA_d = dataA_q;
        if (bus.loadA) begin
            dataA_d = bus.dataAin;
        end
    end

    // Storage flops; the synchronous reset overrides any load at the same edge
    always_ff @(posedge clk) begin
        if (reset) begin
            dataA_q <= '0;
        end else begin
            dataA_q <= dataA_d;
        end
    end

    assign bus.dataAout = dataA_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_a.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_a
//  Description : Directed self-checking bench for reg_a.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_a;

    localparam int WIDTH = 16;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    reg_a_if #(.WIDTH(WIDTH)) bus ();

    reg_a #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [WIDTH-1:0] exp);
        checks = checks + 1;
        if (bus.dataAout !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: dataAout=0x%04h expected=0x%04h", name, bus.dataAout, exp);
        end
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        bus.loadA   = 1'b1;
        bus.dataAin = 16'hFFFF;
        step();
        check("reset_edge1", 16'h0000);
        step();
        check("reset_edge2", 16'h0000);
    endtask

    task automatic test_load();
        reset       = 1'b0;
        bus.loadA   = 1'b1;
        bus.dataAin = 16'h00FE;
        step();
        check("load_00FE", 16'h00FE);
    endtask

    task automatic test_hold();
        bus.loadA   = 1'b0;
        bus.dataAin = 16'h0FE6;
        step();
        check("hold_edge1", 16'h00FE);
        step();
        check("hold_edge2", 16'h00FE);
    endtask

    task automatic test_midcycle();
        bus.loadA = 1'b1;
        step();
        check("load_0FE6", 16'h0FE6);
        #2 bus.dataAin = 16'h1234;
        #1 check("midcycle_toggle", 16'h0FE6);
        bus.dataAin = 16'h0FE6;
        #1 check("midcycle_restore", 16'h0FE6);
        step();
        check("after_toggle_edge", 16'h0FE6);
        // Reset asserted between edges must wait for the next edge
        #1 reset = 1'b1;
        #1 check("reset_between_edges", 16'h0FE6);
        step();
        check("reset_at_edge", 16'h0000);
        // After reset, the value stays zero until a load
        reset       = 1'b0;
        bus.loadA   = 1'b0;
        bus.dataAin = 16'h5555;
        step();
        check("post_reset_idle1", 16'h0000);
        step();
        check("post_reset_idle2", 16'h0000);
    endtask

    task automatic test_reset_priority();
        bus.loadA   = 1'b1;
        bus.dataAin = 16'hA5A5;
        reset       = 1'b1;
        step();
        check("reset_over_load", 16'h0000);
        reset = 1'b0;
        step();
        check("load_after_reset", 16'hA5A5);
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] vals [3];
        vals[0] = 16'h0001;
        vals[1] = 16'h8000;
        vals[2] = 16'hFFFF;
        bus.loadA = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.dataAin = vals[i];
            step();
            check($sformatf("b2b_%0d", i), vals[i]);
        end
        bus.loadA   = 1'b0;
        bus.dataAin = 16'h0000;
        step();
        check("b2b_hold", 16'hFFFF);
        // Reset in the middle of a load stream, then resume
        bus.loadA   = 1'b1;
        bus.dataAin = 16'h1111;
        step();
        check("stream_1111", 16'h1111);
        bus.dataAin = 16'h3333;
        reset       = 1'b1;
        step();
        check("stream_reset", 16'h0000);
        reset       = 1'b0;
        bus.dataAin = 16'h2222;
        step();
        check("stream_resume", 16'h2222);
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        reset       = 1'b1;
        bus.loadA   = 1'b0;
        bus.dataAin = '0;
        #1;
        test_reset();
        test_load();
        test_hold();
        test_midcycle();
        test_reset_priority();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
